move_sequencer: RTL and testbench

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer
//
// Applies one 2048-style slide/merge move to a 4x4 board held in an external
// synchronous-read tile RAM. Each of the four lines along the move direction is
// read (4 cycles + 1 wait), merged in one cycle and written back (4 cycles),
// so a full move takes 40 cycles followed by a one-cycle done pulse.
//
// Ports
//   clk        system clock, rising edge active
//   rst        asynchronous, active-high reset
//   cmd_valid  move request
//   cmd_dir    direction: 0 left, 1 right, 2 up, 3 down
//   cmd_ready  high only while idle; request taken when valid && ready
//   mem_addr   tile RAM address (row*4+col)
//   mem_we     tile RAM write enable
//   mem_wdata  tile exponent to write (0 = empty, e = value 2^e)
//   mem_rdata  tile RAM read data, valid one cycle after mem_addr
//   done       one-cycle pulse at move completion
//   moved      valid with done: some tile changed
//   score_add  valid with done: saturating sum of merged tile values
// -----------------------------------------------------------------------------
module move_sequencer #(
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_dir,
  output logic               cmd_ready,
  output logic [3:0]         mem_addr,
  output logic               mem_we,
  output logic [3:0]         mem_wdata,
  input  logic [3:0]         mem_rdata,
  output logic               done,
  output logic               moved,
  output logic [SCORE_W-1:0] score_add
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    RWAIT = 3'd2,
    PROC  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Result of merging one line: new tiles plus the score earned by it.
  typedef struct packed {
    logic [3:0][3:0] tiles;
    logic [17:0]     score;
  } line_t;

  // RAM address of position k on line l for the given direction.
  function automatic logic [3:0] addr_of(input logic [1:0] dir,
                                         input logic [1:0] l,
                                         input logic [1:0] k);
    logic [3:0] a;
    case (dir)
      2'd0:    a = {l, k};
      2'd1:    a = {l, 2'd3 - k};
      2'd2:    a = {k, l};
      2'd3:    a = {2'd3 - k, l};
      default: a = {l, k};
    endcase
    return a;
  endfunction

  // Compress toward slot 0, merge equal neighbours once each, pad with zeros.
  function automatic line_t merge_line(input logic [3:0][3:0] s);
    logic [4:0][3:0] c;  // extra zero entry so c[j+1] is always in range
    logic [2:0]      n;
    logic [2:0]      m;
    logic            skip;
    line_t           o;
    c = '0;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (s[i] != 4'd0) begin
        c[n] = s[i];
        n    = n + 3'd1;
      end
    end
    o    = '0;
    m    = 3'd0;
    skip = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (skip) begin
        // second tile of a pair already consumed by the merge
        skip = 1'b0;
      end else if (c[j] != 4'd0) begin
        if (c[j+1] == c[j]) begin
          o.tiles[m[1:0]] = (c[j] == 4'd15) ? 4'd15 : (c[j] + 4'd1);
          o.score         = o.score + (18'd1 << ({1'b0, c[j]} + 5'd1));
          skip            = 1'b1;
        end else begin
          o.tiles[m[1:0]] = c[j];
        end
        m = m + 3'd1;
      end
    end
    return o;
  endfunction

  // Accumulator add clamped at the all-ones value of SCORE_W bits.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [17:0]        b);
    logic [SCORE_W+18:0] sum;
    sum = {19'd0, a} + {{(SCORE_W+1){1'b0}}, b};
    if (sum > {19'd0, {SCORE_W{1'b1}}}) begin
      return {SCORE_W{1'b1}};
    end else begin
      return sum[SCORE_W-1:0];
    end
  endfunction

  state_t                state_r, state_s;
  logic [1:0]            k_r, k_s;
  logic [1:0]            l_r, l_s;
  logic [1:0]            dir_r, dir_s;
  logic [3:0][3:0]       slot_r;
  logic [3:0][3:0]       res_r, res_s;
  logic                  moved_acc_r;
  logic [SCORE_W-1:0]    score_acc_r;
  line_t                 line_s;
  logic                  line_moved_s;

  logic                  cmd_ready_s;
  logic                  mem_we_s;
  logic                  done_s;
  logic [3:0]            mem_addr_s;
  logic [3:0]            mem_wdata_s;

  assign line_s       = merge_line(slot_r);
  assign line_moved_s = (line_s.tiles != slot_r);

  // Next-state logic: position k / line l counters walk the line sequence.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    l_s     = l_r;
    dir_s   = dir_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          state_s = READ;
          dir_s   = cmd_dir;
          l_s     = 2'd0;
          k_s     = 2'd0;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (k_r == 2'd3) begin
          state_s = RWAIT;
          k_s     = 2'd0;
        end else begin
          k_s = k_r + 2'd1;
        end
      end
      RWAIT: begin
        state_s = PROC;
      end
      PROC: begin
        state_s = WRITE;
        k_s     = 2'd0;
      end
      WRITE: begin
        if (k_r == 2'd3) begin
          k_s = 2'd0;
          if (l_r == 2'd3) begin
            state_s = DONE;
          end else begin
            state_s = READ;
            l_s     = l_r + 2'd1;
          end
        end else begin
          k_s = k_r + 2'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        k_s     = 2'd0;
        l_s     = 2'd0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a register.
  always_comb begin
    res_s       = res_r;
    cmd_ready_s = (state_s == IDLE);
    mem_we_s    = (state_s == WRITE);
    done_s      = (state_s == DONE);
    mem_addr_s  = 4'd0;
    mem_wdata_s = 4'd0;
    if (state_r == PROC) begin
      res_s = line_s.tiles;
    end else begin
      res_s = res_r;
    end
    if ((state_s == READ) || (state_s == WRITE)) begin
      mem_addr_s = addr_of(dir_s, l_s, k_s);
    end else begin
      mem_addr_s = 4'd0;
    end
    if (state_s == WRITE) begin
      mem_wdata_s = res_s[k_s];
    end else begin
      mem_wdata_s = 4'd0;
    end
  end

  // FSM state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      k_r     <= 2'd0;
      l_r     <= 2'd0;
      dir_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      l_r     <= l_s;
      dir_r   <= dir_s;
    end
  end

  // Line datapath: read capture (one cycle behind the address), merge result
  // and the per-move moved/score accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_r      <= '0;
      res_r       <= '0;
      moved_acc_r <= 1'b0;
      score_acc_r <= '0;
    end else begin
      res_r <= res_s;
      if ((state_r == READ) && (k_r != 2'd0)) begin
        slot_r[k_r - 2'd1] <= mem_rdata;
      end else if (state_r == RWAIT) begin
        slot_r[3] <= mem_rdata;
      end else begin
        slot_r <= slot_r;
      end
      if ((state_r == IDLE) && cmd_valid) begin
        moved_acc_r <= 1'b0;
        score_acc_r <= '0;
      end else if (state_r == PROC) begin
        moved_acc_r <= moved_acc_r | line_moved_s;
        score_acc_r <= sat_add(score_acc_r, line_s.score);
      end else begin
        moved_acc_r <= moved_acc_r;
        score_acc_r <= score_acc_r;
      end
    end
  end

  // Registered outputs; moved/score_add load on entry to DONE and then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= 4'd0;
      mem_wdata <= 4'd0;
      done      <= 1'b0;
      moved     <= 1'b0;
      score_add <= '0;
    end else begin
      cmd_ready <= cmd_ready_s;
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
      done      <= done_s;
      if (state_s == DONE) begin
        moved     <= moved_acc_r;
        score_add <= score_acc_r;
      end else begin
        moved     <= moved;
        score_add <= score_add;
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_move_sequencer
//
// Drives move_sequencer against a behavioural tile RAM. The stimulus side
// pushes the expected board/moved/score/latency of every accepted move into a
// queue; a monitor pops and compares whenever done pulses.
// -----------------------------------------------------------------------------
module tb_move_sequencer;

  localparam int SCORE_W = 16;

  typedef logic [15:0][3:0] board_t;

  typedef struct packed {
    logic        moved;
    logic [31:0] score;
    logic [63:0] board;
    logic [31:0] acc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic [1:0]         cmd_dir = 2'd0;
  logic               cmd_ready;
  logic [3:0]         mem_addr;
  logic               mem_we;
  logic [3:0]         mem_wdata;
  logic [3:0]         mem_rdata;
  logic               done;
  logic               moved;
  logic [SCORE_W-1:0] score_add;

  board_t ram;
  board_t ld_board = '0;
  logic   ld_en = 1'b0;
  board_t exp_board = '0;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   chain = 1'b0;
  exp_t sbq[$];

  move_sequencer #(.SCORE_W(SCORE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_ready (cmd_ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .done      (done),
    .moved     (moved),
    .score_add (score_add)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read tile RAM with a whole-board preload port for the bench.
  always @(posedge clk) begin
    if (ld_en) ram <= ld_board;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk each line in move order, slide, merge pairs, pad.
  function automatic void model(input board_t b, input logic [1:0] d,
                                output board_t o, output logic mv, output logic [31:0] sc);
    longint total;
    int pos[4];
    int q[$];
    int r[$];
    int i;
    total = 0;
    o = b;
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 4; k++) begin
        case (d)
          2'd0: pos[k] = 4 * l + k;
          2'd1: pos[k] = 4 * l + (3 - k);
          2'd2: pos[k] = 4 * k + l;
          default: pos[k] = 4 * (3 - k) + l;
        endcase
      end
      q.delete();
      r.delete();
      for (int k = 0; k < 4; k++) if (b[pos[k]] != 0) q.push_back(int'(b[pos[k]]));
      i = 0;
      while (i < q.size()) begin
        if (i + 1 < q.size() && q[i] == q[i+1]) begin
          r.push_back((q[i] + 1 > 15) ? 15 : q[i] + 1);
          total += longint'(1) << (q[i] + 1);
          i += 2;
        end else begin
          r.push_back(q[i]);
          i += 1;
        end
      end
      while (r.size() < 4) r.push_back(0);
      for (int k = 0; k < 4; k++) o[pos[k]] = 4'(r[k]);
    end
    mv = (o != b);
    if (total > (longint'(1) << SCORE_W) - 1) total = (longint'(1) << SCORE_W) - 1;
    sc = 32'(total);
  endfunction

  task automatic load_board(input board_t b);
    ld_board = b;
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    exp_board = b;
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [1:0] d, input bit hold, input bit push);
    int n;
    int acc;
    board_t nb;
    logic mv;
    logic [31:0] sc;
    cmd_valid = 1'b1;
    cmd_dir = d;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      chain = 1'b0;
    end else begin
      acc = cyc + 1;
      if (chain) check("held_accept_cycle", 64'(acc - last_acc), 64'd42);
      last_acc = acc;
      chain = hold;
      if (push) begin
        model(exp_board, d, nb, mv, sc);
        sbq.push_back('{moved: mv, score: sc, board: 64'(nb), acc: 32'(acc)});
        exp_board = nb;
      end
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_cycle(input int c);
    int n;
    n = 0;
    while ((cyc - last_acc + 1) < c && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic board_t rand_board();
    board_t b;
    int r;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 10);
      if (r < 4) b[i] = 4'd0;
      else if (r == 10) b[i] = 4'(14 + $urandom_range(0, 1));
      else b[i] = 4'(r - 3);
    end
    return b;
  endfunction

  // Scoreboard monitor plus idle-output checks, sampled on the falling edge.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_prev = 1'b0;
      end else begin
        if (done) begin
          check("done_one_cycle", 64'(done_prev), 64'd0);
          if (sbq.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sbq.pop_front();
            check("moved", 64'(moved), 64'(e.moved));
            check("score_add", 64'(score_add), 64'(e.score));
            check("board", 64'(ram), e.board);
            check("done_cycle", 64'(cyc - int'(e.acc) + 1), 64'd41);
          end
        end
        if (cmd_ready) check("idle_outputs", {mem_we, mem_addr, mem_wdata}, 64'd0);
        if (!mem_we) check("wdata_outside_write", 64'(mem_wdata), 64'd0);
        done_prev = done;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    board_t b;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_outputs", {mem_we, mem_addr, mem_wdata, done, moved}, 64'd0);
    check("rst_score", 64'(score_add), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Row 0 = 1,1,2,2 slid left
    b = '0; b[0] = 4'd1; b[1] = 4'd1; b[2] = 4'd2; b[3] = 4'd2;
    load_board(b);
    issue(2'd0, 1'b0, 1'b1);
    wait_drain();
    check("t031_row0", 64'({ram[3], ram[2], ram[1], ram[0]}), 64'h0032);
    check("t031_score", 64'(score_add), 64'd12);
    check("t031_moved", 64'(moved), 64'd1);

    // Row 0 = 1,1,1,1 slid right
    b = '0; b[0] = 4'd1; b[1] = 4'd1; b[2] = 4'd1; b[3] = 4'd1;
    load_board(b);
    issue(2'd1, 1'b0, 1'b1);
    wait_drain();
    check("t032_row0", 64'({ram[3], ram[2], ram[1], ram[0]}), 64'h2200);
    check("t032_score", 64'(score_add), 64'd8);

    // Column 0 = 0,2,0,2 slid up
    b = '0; b[4] = 4'd2; b[12] = 4'd2;
    load_board(b);
    issue(2'd2, 1'b0, 1'b1);
    wait_drain();
    check("t033_col0", 64'({ram[12], ram[8], ram[4], ram[0]}), 64'h0003);
    check("t033_score", 64'(score_add), 64'd8);
    check("t033_moved", 64'(moved), 64'd1);

    // Full checkerboard, all four directions with cmd_valid held throughout
    for (int i = 0; i < 16; i++) b[i] = 4'(1 + (((i / 4) + (i % 4)) % 2));
    load_board(b);
    issue(2'd0, 1'b1, 1'b1);
    issue(2'd1, 1'b1, 1'b1);
    issue(2'd2, 1'b1, 1'b1);
    issue(2'd3, 1'b0, 1'b1);
    wait_drain();
    check("t034_board", 64'(ram), 64'(b));
    check("t034_moved", 64'(moved), 64'd0);
    check("t034_score", 64'(score_add), 64'd0);

    // 15,15 merge: tile and score both saturate
    b = '0; b[0] = 4'd15; b[1] = 4'd15;
    load_board(b);
    issue(2'd0, 1'b0, 1'b1);
    wait_drain();
    check("t035_row0", 64'({ram[1], ram[0]}), 64'h0F);
    check("t035_score", 64'(score_add), 64'd65535);

    // Abort during a write cycle: mem_we must fall without a clock edge
    b = '0; b[0] = 4'd1; b[1] = 4'd1; b[2] = 4'd2; b[3] = 4'd2;
    load_board(b);
    issue(2'd0, 1'b0, 1'b0);
    wait_cycle(8);
    check("abort8_we_before", 64'(mem_we), 64'd1);
    rst = 1'b1;
    #1;
    check("abort8_async", {mem_we, mem_addr, mem_wdata, done, cmd_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    check("abort8_row0", 64'({ram[3], ram[2], ram[1], ram[0]}), 64'h2212);

    // Abort in cycle 15: line 0 fully written, no done afterwards
    load_board(b);
    issue(2'd0, 1'b0, 1'b0);
    wait_cycle(15);
    rst = 1'b1;
    #1;
    check("abort15_async", {mem_we, mem_addr, mem_wdata, done}, 64'd0);
    check("abort15_result", {moved, 16'(score_add)}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort15_row0", 64'({ram[3], ram[2], ram[1], ram[0]}), 64'h0032);
    @(negedge clk);
    check("abort15_ready", 64'(cmd_ready), 64'd1);
    repeat (60) @(negedge clk);

    // Random boards and directions, some back-to-back with cmd_valid held
    for (int t = 0; t < 28; t++) begin
      bit hold;
      hold = (t < 27) && ($urandom_range(0, 2) == 0);
      if (!chain && (t % 3 == 0)) load_board(rand_board());
      issue(2'($urandom_range(0, 3)), hold, 1'b1);
      if (!hold) wait_drain();
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
